// File: rtl/pipe_skid_reg_pkg.sv
// pipe_pkg: shared types and defaults for the skid-buffered pipeline stage register.
//   pipe_payload_t : {instr, pc, bd, exc} at the default widths
//   pipe_state_e   : EMPTY / FULL / SKID occupancy states
//   EXC_NONE       : exception code meaning "no exception"
//   HANDLER_PC_DEF : default exception handler pc
package pipe_pkg;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF = 32;
    localparam int EXC_W_DEF = 5;
    localparam int EXC_NONE = 0;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_e;
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
        logic                   bd;
        logic [EXC_W_DEF-1:0]   exc;
    } pipe_payload_t;
endpackage

// File: rtl/pipe_skid_reg_payload_slot.sv
// pipe_payload_slot: one payload register with synchronous load and clear.
//   clk, reset : clock, asynchronous active-high reset (q <= RST_VAL)
//   load, d    : capture d
//   clear      : zero the slot (wins over load)
//   q          : stored payload
module pipe_payload_slot
    import pipe_pkg::*;
#(
    parameter int W = $bits(pipe_payload_t),
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= RST_VAL;
        else if (clear) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with a 2-entry skid buffer, flush and exception bubble.
//   clk, reset          : clock, asynchronous active-high reset
//   exc_req, flush      : exception bubble (pc <= HANDLER_PC) / squash; exc_req has priority
//   in_valid, in_ready  : upstream handshake; in_ready is registered (= skid empty)
//   in_instr/pc/bd/exc  : upstream payload
//   out_valid, out_ready: downstream handshake
//   out_instr/pc/bd/exc : main-entry payload
//   stall_cnt           : saturating count of out_valid & !out_ready cycles,
//                         built only when PIPE_SKID_STALL_CNT_EN is defined (else 0)
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W = PC_W_DEF,
    parameter int EXC_W = EXC_W_DEF,
    parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(HANDLER_PC_DEF),
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exc_req,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_bd,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_bd,
    output logic [EXC_W-1:0]   out_exc,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               bd;
        logic [EXC_W-1:0]   exc;
    } payload_t;
    localparam int W = $bits(payload_t);
    localparam payload_t MAIN_RST = '{instr: '0, pc: RESET_PC, bd: 1'b0, exc: '0};
    pipe_state_e state;
    payload_t in_p, main_q, skid_q, main_d, exc_p, flush_p;
    logic in_xfer, out_xfer, kill, main_from_skid, main_load, skid_load, skid_clear;
    assign in_xfer = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign kill = exc_req | flush;
    // skid is occupied exactly when in_ready is low
    assign main_from_skid = !in_ready & out_xfer;
    assign main_load = kill | main_from_skid | (in_xfer & (!out_valid | out_xfer));
    assign skid_load = !kill & in_xfer & out_valid & !out_xfer;
    assign skid_clear = kill | main_from_skid;
    assign in_p = '{instr: in_instr, pc: in_pc, bd: in_bd, exc: in_exc};
    assign exc_p = '{instr: '0, pc: HANDLER_PC, bd: 1'b0, exc: EXC_W'(EXC_NONE)};
    // flush turns the main entry into a nop but keeps pc/bd/exc for pc tracking
    assign flush_p = '{instr: '0, pc: main_q.pc, bd: main_q.bd, exc: main_q.exc};
    always_comb main_d = exc_req ? exc_p : flush ? flush_p : main_from_skid ? skid_q : in_p;
    pipe_payload_slot #(.W(W), .RST_VAL(MAIN_RST)) u_main (
        .clk(clk), .reset(reset), .load(main_load), .clear(1'b0), .d(main_d), .q(main_q)
    );
    pipe_payload_slot #(.W(W), .RST_VAL('0)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear), .d(in_p), .q(skid_q)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
        end else if (kill) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
        end else
            case (state)
                EMPTY: if (in_xfer) begin
                    state <= FULL;
                    out_valid <= 1'b1;
                end
                FULL: if (in_xfer && !out_xfer) begin
                    state <= SKID;
                    in_ready <= 1'b0;
                end else if (!in_xfer && out_xfer) begin
                    state <= EMPTY;
                    out_valid <= 1'b0;
                end
                SKID: if (out_xfer) begin
                    state <= FULL;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
    assign out_instr = main_q.instr;
    assign out_pc = main_q.pc;
    assign out_bd = main_q.bd;
    assign out_exc = main_q.exc;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (out_valid && !out_ready && !(&cnt)) cnt <= cnt + 1'b1;
    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed self-checking bench for pipe_skid_reg.
module tb_pipe_skid_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_req = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_exc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        out_bd;
    logic [4:0]  out_exc;
    logic [3:0]  stall_cnt;
    int n_cmp = 0, n_err = 0;
    pipe_skid_reg #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .exc_req(exc_req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_bd(in_bd), .in_exc(in_exc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
        .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc = pc;
        in_instr = instr;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_bd", out_bd, 0);
        chk("rst_out_exc", out_exc, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b0;
        // 1: streaming, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
            chk("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
            chk("stream_instr", out_instr, 32'h1000 + 32'(i));
            chk("stream_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        drive(1'b0, '0, '0);
        tick();
        chk("drain_valid", out_valid, 0);
        // 2: back-pressure into skid, in-order drain
        out_ready = 1'b0;
        drive(1'b1, 32'h3000, 32'hA0);
        tick();
        chk("full_pc", out_pc, 32'h3000);
        chk("full_in_ready", in_ready, 1);
        drive(1'b1, 32'h3004, 32'hA1);
        tick();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_pc_held", out_pc, 32'h3000);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        chk("skid_drain_pc", out_pc, 32'h3004);
        chk("skid_drain_instr", out_instr, 32'hA1);
        chk("skid_drain_valid", out_valid, 1);
        chk("skid_drain_in_ready", in_ready, 1);
        tick();
        chk("skid_empty_valid", out_valid, 0);
        // 3: exc_req from SKID with in_valid
        out_ready = 1'b0;
        drive(1'b1, 32'h3008, 32'hB0);
        tick();
        drive(1'b1, 32'h300C, 32'hB1);
        tick();
        chk("exc_pre_in_ready", in_ready, 0);
        drive(1'b1, 32'h3010, 32'hB2);
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        chk("exc_valid", out_valid, 0);
        chk("exc_pc", out_pc, 32'h4180);
        chk("exc_instr", out_instr, 0);
        chk("exc_in_ready", in_ready, 1);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        chk("exc_skid_cleared", out_valid, 0);
        drive(1'b1, 32'h3014, 32'hB3);
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        chk("exc_drop_in_xfer", out_valid, 0);
        // 4: flush+exc_req, then flush alone
        out_ready = 1'b0;
        drive(1'b1, 32'h3008, 32'h55);
        tick();
        drive(1'b0, '0, '0);
        flush = 1'b1;
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        flush = 1'b0;
        chk("fe_pc", out_pc, 32'h4180);
        chk("fe_valid", out_valid, 0);
        drive(1'b1, 32'h3008, 32'h77);
        in_bd = 1'b1;
        in_exc = 5'd7;
        tick();
        in_bd = 1'b0;
        in_exc = 5'd0;
        drive(1'b1, 32'h300C, 32'h78);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_pc", out_pc, 32'h3008);
        chk("flush_instr", out_instr, 0);
        chk("flush_bd", out_bd, 1);
        chk("flush_exc", out_exc, 7);
        chk("flush_in_ready", in_ready, 1);
        // 5: exception code and delay-slot flag pass-through
        out_ready = 1'b1;
        drive(1'b1, 32'h3010, 32'hC0);
        in_exc = 5'd10;
        in_bd = 1'b1;
        tick();
        chk("exc10_code", out_exc, 10);
        chk("exc10_bd", out_bd, 1);
        drive(1'b1, 32'h3014, 32'hC1);
        in_exc = 5'd0;
        in_bd = 1'b0;
        tick();
        chk("exc0_code", out_exc, 0);
        chk("exc0_bd", out_bd, 0);
        chk("exc0_pc", out_pc, 32'h3014);
        // 6: stall counter and async reset mid-stall
        drive(1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h3020, 32'hD0);
        tick();
        drive(1'b0, '0, '0);
        repeat (20) tick();
        chk("stall_valid", out_valid, 1);
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_cnt_sat", stall_cnt, 15);
`else
        chk("stall_cnt_off", stall_cnt, 0);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", stall_cnt, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_pc", out_pc, 0);
        tick();
        reset = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
